cnn_layer_accel_fas_core: RTL and testbench

Single-clock job controller for the FAS (feature-accumulation stage) of the CNN layer accelerator.
- The host programs a config-packet base address and issues a start over the target port.
- The block fetches one config packet over the initiator read channel, streams the source map through a small FIFO while applying an opcode, and writes the result over the initiator write channel.
- On completion it raises a user interrupt that is held until acknowledged.

---
 rtl/cnn_layer_accel_fas_pkg.sv | 33 +++
 rtl/cnn_layer_accel_fas_core_if.sv | 69 ++++++
 rtl/fas_stream_fifo.sv | 42 ++++
 rtl/cnn_layer_accel_fas_core.sv | 209 ++++++++++++++++++++
 tb/tb_cnn_layer_accel_fas_core.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_layer_accel_fas_pkg.sv
// Shared types and constants for the FAS job controller: FSM states,
// target register map, opcodes and config-packet field positions.
package cnn_layer_accel_fas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG_REQ  = 3'd1,
        ST_CFG_DATA = 3'd2,
        ST_STRM_REQ = 3'd3,
        ST_STRM     = 3'd4,
        ST_IRQ      = 3'd5
    } fas_state_t;

    // Target write map uses CFG_BASE/START, read map uses STATUS/CFG_BASE.
    localparam logic REG_CFG_BASE = 1'b0;
    localparam logic REG_START    = 1'b1;
    localparam logic REG_STATUS   = 1'b0;

    localparam logic [7:0] OP_COPY = 8'd0;
    localparam logic [7:0] OP_RELU = 8'd1;

    localparam int PKT_SRC_LSB = 0;
    localparam int PKT_DST_LSB = 32;
    localparam int PKT_LEN_LSB = 64;
    localparam int PKT_OP_LSB  = 80;

    localparam int LANE_W = 16;

    function automatic logic op_is_known(input logic [7:0] op);
        return (op == OP_COPY) || (op == OP_RELU);
    endfunction

endpackage

// File: rtl/cnn_layer_accel_fas_core_if.sv
// Bundle of the target (host register) port and the initiator read/write
// channels. The slave modport is the accelerator core, master is its environment.
interface cnn_layer_accel_fas_core_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int DATA_W = 128,
    parameter int TARG_W = 32
) ();

    // Handshakes: a data beat moves on the clock edge where vld and rdy are
    // both high, and vld/data hold until then; req/addr/len hold until the
    // edge where req_ack is high; acks, cmpl and target strobes are pulses.
    logic              targ_write_addr;
    logic              targ_write_addr_vld;
    logic [TARG_W-1:0] targ_write_data;
    logic              targ_write_ack;
    logic              targ_read_addr;
    logic              targ_read_addr_vld;
    logic [TARG_W-1:0] targ_read_data;
    logic              targ_read_ack;

    logic              init_read_req;
    logic [ADDR_W-1:0] init_read_addr;
    logic [LEN_W-1:0]  init_read_len;
    logic              init_read_req_ack;
    logic [DATA_W-1:0] init_read_data;
    logic              init_read_data_vld;
    logic              init_read_data_rdy;
    logic              init_read_cmpl;

    logic              init_write_req;
    logic [ADDR_W-1:0] init_write_addr;
    logic [LEN_W-1:0]  init_write_len;
    logic              init_write_req_ack;
    logic [DATA_W-1:0] init_write_data;
    logic              init_write_data_vld;
    logic              init_write_data_rdy;
    logic              init_write_cmpl;

    logic              init_usrIntr;
    logic              init_usrIntr_ack;

    modport slave (
        input  targ_write_addr, targ_write_addr_vld, targ_write_data,
        input  targ_read_addr, targ_read_addr_vld,
        output targ_write_ack, targ_read_data, targ_read_ack,
        output init_read_req, init_read_addr, init_read_len, init_read_data_rdy,
        input  init_read_req_ack, init_read_data, init_read_data_vld, init_read_cmpl,
        output init_write_req, init_write_addr, init_write_len,
        output init_write_data, init_write_data_vld,
        input  init_write_req_ack, init_write_data_rdy, init_write_cmpl,
        output init_usrIntr,
        input  init_usrIntr_ack
    );

    modport master (
        output targ_write_addr, targ_write_addr_vld, targ_write_data,
        output targ_read_addr, targ_read_addr_vld,
        input  targ_write_ack, targ_read_data, targ_read_ack,
        input  init_read_req, init_read_addr, init_read_len, init_read_data_rdy,
        output init_read_req_ack, init_read_data, init_read_data_vld, init_read_cmpl,
        input  init_write_req, init_write_addr, init_write_len,
        input  init_write_data, init_write_data_vld,
        output init_write_req_ack, init_write_data_rdy, init_write_cmpl,
        input  init_usrIntr,
        output init_usrIntr_ack
    );

endinterface

// File: rtl/fas_stream_fifo.sv
// Synchronous stream buffer between the initiator read and write channels.
// Callers never push when full nor pop when empty.
module fas_stream_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointers carry one wrap bit so full and empty stay distinguishable.
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/cnn_layer_accel_fas_core.sv
// FAS job controller: config fetch, opcode-applied stream copy, done interrupt.
// Optional macro FAS_PERF_CNT_EN adds a busy-cycle counter readable at addr 1.
module cnn_layer_accel_fas_core
    import cnn_layer_accel_fas_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int DATA_W     = 128,
    parameter int TARG_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk_intf,
    input  logic                      rst,
    cnn_layer_accel_fas_core_if.slave bus,
    output fas_state_t                dbg_state
);
    fas_state_t        state, state_next;
    logic [ADDR_W-1:0] cfg_base;
    logic [31:0]       pkt_src, pkt_dst;
    logic [LEN_W-1:0]  pkt_len, len_now;
    logic [7:0]        pkt_op;
    logic              busy, done, err;
    logic              rd_acked, wr_acked, rd_cmpl_seen, wr_cmpl_seen;
    logic              start_go, pkt_take;
    logic              write_ack_q, read_ack_q;
    logic [TARG_W-1:0] read_data_q, read_alt;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout, wr_word;
    logic [LANE_W-1:0] lane;
    logic              rd_req, rd_rdy, wr_req, wr_vld, irq;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [LEN_W-1:0]  rd_len, wr_len;

    assign start_go = bus.targ_write_addr_vld && (bus.targ_write_addr == REG_START)
                      && (state == ST_IDLE);
    assign pkt_take = (state == ST_CFG_DATA) && bus.init_read_data_vld;
    // The packet may arrive in the same cycle as its cmpl, so look through.
    assign len_now  = pkt_take ? bus.init_read_data[PKT_LEN_LSB +: LEN_W] : pkt_len;

    always_ff @(posedge clk_intf) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (start_go) state_next = ST_CFG_REQ;
            ST_CFG_REQ:  if (bus.init_read_req_ack) state_next = ST_CFG_DATA;
            ST_CFG_DATA: if (bus.init_read_cmpl)
                             state_next = (len_now == '0) ? ST_IRQ : ST_STRM_REQ;
            ST_STRM_REQ: if ((rd_acked || bus.init_read_req_ack) &&
                             (wr_acked || bus.init_write_req_ack)) state_next = ST_STRM;
            ST_STRM:     if ((rd_cmpl_seen || bus.init_read_cmpl) &&
                             (wr_cmpl_seen || bus.init_write_cmpl)) state_next = ST_IRQ;
            ST_IRQ:      if (bus.init_usrIntr_ack) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_req  = 1'b0;
        rd_addr = '0;
        rd_len  = '0;
        rd_rdy  = 1'b0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_len  = '0;
        wr_vld  = 1'b0;
        irq     = 1'b0;
        case (state)
            ST_CFG_REQ: begin
                rd_req  = 1'b1;
                rd_addr = cfg_base;
                rd_len  = LEN_W'(1);
            end
            ST_CFG_DATA: rd_rdy = 1'b1;
            ST_STRM_REQ: begin
                if (!rd_acked) begin
                    rd_req  = 1'b1;
                    rd_addr = ADDR_W'(pkt_src);
                    rd_len  = pkt_len;
                end
                if (!wr_acked) begin
                    wr_req  = 1'b1;
                    wr_addr = ADDR_W'(pkt_dst);
                    wr_len  = pkt_len;
                end
            end
            ST_STRM: begin
                rd_rdy = !fifo_full;
                wr_vld = !fifo_empty;
            end
            ST_IRQ:  irq = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_intf) begin
        if (!rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            pkt_src      <= '0;
            pkt_dst      <= '0;
            pkt_len      <= '0;
            pkt_op       <= '0;
            rd_acked     <= 1'b0;
            wr_acked     <= 1'b0;
            rd_cmpl_seen <= 1'b0;
            wr_cmpl_seen <= 1'b0;
        end else begin
            if (start_go) begin
                busy <= 1'b1;
                done <= 1'b0;
                err  <= 1'b0;
            end else if (state != ST_IRQ && state_next == ST_IRQ) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (pkt_take) begin
                pkt_src <= bus.init_read_data[PKT_SRC_LSB +: 32];
                pkt_dst <= bus.init_read_data[PKT_DST_LSB +: 32];
                pkt_len <= bus.init_read_data[PKT_LEN_LSB +: LEN_W];
                pkt_op  <= bus.init_read_data[PKT_OP_LSB +: 8];
                if (!op_is_known(bus.init_read_data[PKT_OP_LSB +: 8])) err <= 1'b1;
            end
            rd_acked     <= (state == ST_STRM_REQ) && (rd_acked || bus.init_read_req_ack);
            wr_acked     <= (state == ST_STRM_REQ) && (wr_acked || bus.init_write_req_ack);
            rd_cmpl_seen <= (state == ST_STRM) && (rd_cmpl_seen || bus.init_read_cmpl);
            wr_cmpl_seen <= (state == ST_STRM) && (wr_cmpl_seen || bus.init_write_cmpl);
        end
    end

`ifdef FAS_PERF_CNT_EN
    logic [31:0] perf_cnt;
    always_ff @(posedge clk_intf) begin
        if (!rst || start_go)              perf_cnt <= '0;
        else if (busy && perf_cnt != '1)   perf_cnt <= perf_cnt + 32'd1;
    end
    assign read_alt = TARG_W'(perf_cnt);
`else
    assign read_alt = TARG_W'(cfg_base);
`endif

    always_ff @(posedge clk_intf) begin
        if (!rst) begin
            cfg_base    <= '0;
            write_ack_q <= 1'b0;
            read_ack_q  <= 1'b0;
            read_data_q <= '0;
        end else begin
            write_ack_q <= bus.targ_write_addr_vld;
            read_ack_q  <= bus.targ_read_addr_vld;
            if (bus.targ_write_addr_vld && bus.targ_write_addr == REG_CFG_BASE)
                cfg_base <= ADDR_W'(bus.targ_write_data);
            if (!bus.targ_read_addr_vld)
                read_data_q <= '0;
            else if (bus.targ_read_addr == REG_STATUS)
                read_data_q <= TARG_W'({err, done, busy});
            else
                read_data_q <= read_alt;
        end
    end

    assign fifo_push = (state == ST_STRM) && bus.init_read_data_vld && !fifo_full;
    assign fifo_pop  = wr_vld && bus.init_write_data_rdy;

    fas_stream_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_intf),
        .rst   (rst),
        .flush (start_go),
        .push  (fifo_push),
        .din   (bus.init_read_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Opcode is applied at the FIFO head so the buffer holds raw source words.
    always_comb begin
        wr_word = '0;
        lane    = '0;
        if (wr_vld) begin
            for (int i = 0; i < DATA_W / LANE_W; i++) begin
                lane = fifo_dout[i*LANE_W +: LANE_W];
                wr_word[i*LANE_W +: LANE_W] =
                    (pkt_op == OP_RELU && lane[LANE_W-1]) ? '0 : lane;
            end
        end
    end

    assign bus.targ_write_ack      = write_ack_q;
    assign bus.targ_read_ack       = read_ack_q;
    assign bus.targ_read_data      = read_data_q;
    assign bus.init_read_req       = rd_req;
    assign bus.init_read_addr      = rd_addr;
    assign bus.init_read_len       = rd_len;
    assign bus.init_read_data_rdy  = rd_rdy;
    assign bus.init_write_req      = wr_req;
    assign bus.init_write_addr     = wr_addr;
    assign bus.init_write_len      = wr_len;
    assign bus.init_write_data     = wr_word;
    assign bus.init_write_data_vld = wr_vld;
    assign bus.init_usrIntr        = irq;
    assign dbg_state               = state;

endmodule

// File: tb/tb_cnn_layer_accel_fas_core.sv
// Directed bench for the FAS job controller; write-side words are checked
// against an expected queue filled as the source words are offered.
module tb_cnn_layer_accel_fas_core;
  import cnn_layer_accel_fas_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  fas_state_t dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int wr_count = 0;
  int rd_pushed = 0;
  logic [127:0] exp_q[$];
  logic [127:0] src_words[$];
  logic [127:0] ref_words[$];

  cnn_layer_accel_fas_core_if bus ();

  cnn_layer_accel_fas_core dut (
    .clk_intf  (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted write-side beat must match the queue head.
  always @(negedge clk) begin
    if (rst && bus.init_write_data_vld && bus.init_write_data_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_unexpected: got %0h expected no beat", bus.init_write_data);
      end else begin
        check("wr_data", bus.init_write_data, exp_q.pop_front());
      end
      wr_count++;
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic a, input logic [31:0] d);
    step(1);
    bus.targ_write_addr = a;
    bus.targ_write_data = d;
    bus.targ_write_addr_vld = 1'b1;
    step(1);
    bus.targ_write_addr_vld = 1'b0;
    check("wr_ack", bus.targ_write_ack, 1'b1);
    step(1);
    check("wr_ack_pulse", bus.targ_write_ack, 1'b0);
  endtask

  task automatic host_read(input logic a, output logic [31:0] d);
    step(1);
    bus.targ_read_addr = a;
    bus.targ_read_addr_vld = 1'b1;
    step(1);
    bus.targ_read_addr_vld = 1'b0;
    check("rd_ack", bus.targ_read_ack, 1'b1);
    d = bus.targ_read_data;
    step(1);
    check("rd_ack_pulse", bus.targ_read_ack, 1'b0);
  endtask

  task automatic drive_read(input int len);
    bit ok;
    for (int i = 0; i < len; i++) begin
      bus.init_read_data = src_words[i];
      bus.init_read_data_vld = 1'b1;
      exp_q.push_back(ref_words[i]);
      ok = 1'b0;
      for (int t = 0; t < 300 && !ok; t++) begin
        @(negedge clk);
        ok = bus.init_read_data_rdy;
        step(1);
      end
      if (!ok) begin
        check("rd_accept_timeout", ok, 1'b1);
        break;
      end
      rd_pushed++;
    end
    bus.init_read_data_vld = 1'b0;
    bus.init_read_cmpl = 1'b1;
    step(1);
    bus.init_read_cmpl = 1'b0;
  endtask

  task automatic drive_write(input int len, input int stall);
    logic [31:0] rd;
    bus.init_write_data_rdy = 1'b0;
    if (stall > 0) begin
      host_write(REG_START, 32'h0);
      check("restart_ignored", dbg_state, ST_STRM);
      check("restart_no_cfg_req", bus.init_read_req, 1'b0);
      host_read(REG_STATUS, rd);
      check("status_busy", rd, 32'h1);
      step(stall - 6);
      check("rd_rdy_full", bus.init_read_data_rdy, 1'b0);
      check("rd_pushed_depth", rd_pushed, 16);
      check("wr_vld_stalled", bus.init_write_data_vld, 1'b1);
    end
    bus.init_write_data_rdy = 1'b1;
    for (int t = 0; t < 500 && wr_count < len; t++) step(1);
    check("wr_count", wr_count, len);
    bus.init_write_cmpl = 1'b1;
    step(1);
    bus.init_write_cmpl = 1'b0;
    bus.init_write_data_rdy = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] base, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] len, input logic [7:0] op, input int ack_mode,
                         input int stall, input logic [31:0] exp_status);
    logic [127:0] pkt;
    logic [31:0] rd;
    pkt = {40'hDEADBEEF55, op, len, dst, src};
    wr_count = 0;
    rd_pushed = 0;
    host_write(REG_CFG_BASE, base);
    host_write(REG_START, 32'h0);
    check("cfg_req", bus.init_read_req, 1'b1);
    check("cfg_addr", bus.init_read_addr, base);
    check("cfg_len", bus.init_read_len, 16'd1);
    step(2);
    check("cfg_req_hold", bus.init_read_req, 1'b1);
    bus.init_read_req_ack = 1'b1;
    step(1);
    bus.init_read_req_ack = 1'b0;
    check("cfg_req_drop", bus.init_read_req, 1'b0);
    check("cfg_rdy", bus.init_read_data_rdy, 1'b1);
    bus.init_read_data = pkt;
    bus.init_read_data_vld = 1'b1;
    step(1);
    bus.init_read_data_vld = 1'b0;
    bus.init_read_cmpl = 1'b1;
    step(1);
    bus.init_read_cmpl = 1'b0;
    if (len == 16'd0) begin
      check("len0_no_rd_req", bus.init_read_req, 1'b0);
      check("len0_no_wr_req", bus.init_write_req, 1'b0);
      check("len0_irq_now", bus.init_usrIntr, 1'b1);
    end else begin
      check("strm_rd_req", {bus.init_read_req, bus.init_read_addr, bus.init_read_len},
            {1'b1, src, len});
      check("strm_wr_req", {bus.init_write_req, bus.init_write_addr, bus.init_write_len},
            {1'b1, dst, len});
      if (ack_mode == 0) begin
        bus.init_read_req_ack = 1'b1;
        bus.init_write_req_ack = 1'b1;
        step(1);
        bus.init_read_req_ack = 1'b0;
        bus.init_write_req_ack = 1'b0;
      end else begin
        bus.init_read_req_ack = 1'b1;
        step(1);
        bus.init_read_req_ack = 1'b0;
        check("rd_req_dropped", bus.init_read_req, 1'b0);
        check("wr_req_held", {bus.init_write_req, bus.init_write_addr}, {1'b1, dst});
        step(1);
        bus.init_write_req_ack = 1'b1;
        step(1);
        bus.init_write_req_ack = 1'b0;
      end
      check("strm_state", dbg_state, ST_STRM);
      fork
        drive_read(int'(len));
        drive_write(int'(len), stall);
      join
    end
    for (int t = 0; t < 50 && !bus.init_usrIntr; t++) step(1);
    check("irq", bus.init_usrIntr, 1'b1);
    check("q_drained", exp_q.size(), 0);
    host_read(REG_STATUS, rd);
    check("status_done", rd, exp_status);
    check("irq_hold", bus.init_usrIntr, 1'b1);
    bus.init_usrIntr_ack = 1'b1;
    step(1);
    bus.init_usrIntr_ack = 1'b0;
    check("irq_clear", bus.init_usrIntr, 1'b0);
    check("back_idle", dbg_state, ST_IDLE);
    host_read(REG_STATUS, rd);
    check("status_sticky", rd, exp_status);
  endtask

  task automatic load_words(input logic [127:0] s0, input logic [127:0] s1,
                            input logic [127:0] r0, input logic [127:0] r1);
    src_words.push_back(s0);
    src_words.push_back(s1);
    ref_words.push_back(r0);
    ref_words.push_back(r1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    bus.targ_write_addr = 1'b0;
    bus.targ_write_addr_vld = 1'b0;
    bus.targ_write_data = '0;
    bus.targ_read_addr = 1'b0;
    bus.targ_read_addr_vld = 1'b0;
    bus.init_read_req_ack = 1'b0;
    bus.init_read_data = '0;
    bus.init_read_data_vld = 1'b0;
    bus.init_read_cmpl = 1'b0;
    bus.init_write_req_ack = 1'b0;
    bus.init_write_data_rdy = 1'b0;
    bus.init_write_cmpl = 1'b0;
    bus.init_usrIntr_ack = 1'b0;

    step(3);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_reqs", {bus.init_read_req, bus.init_write_req, bus.init_usrIntr}, 3'b000);
    check("rst_acks", {bus.targ_write_ack, bus.targ_read_ack}, 2'b00);
    check("rst_rdata", bus.targ_read_data, 32'h0);
    check("rst_stream", {bus.init_read_data_rdy, bus.init_write_data_vld}, 2'b00);
    check("rst_wdata", bus.init_write_data, 128'h0);
    rst = 1'b1;
    host_read(REG_STATUS, rd);
    check("status_reset", rd, 32'h0);

    // copy, both stream acks together
    src_words.delete(); ref_words.delete();
    load_words(128'h0001_0002_0003_0004_0005_0006_0007_0008,
               128'hFFFF_8000_7FFF_0000_1111_2222_3333_4444,
               128'h0001_0002_0003_0004_0005_0006_0007_0008,
               128'hFFFF_8000_7FFF_0000_1111_2222_3333_4444);
    load_words(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'hA5A5_5A5A_C3C3_3C3C_F0F0_0F0F_8001_0001,
               128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'hA5A5_5A5A_C3C3_3C3C_F0F0_0F0F_8001_0001);
    run_job(32'h1000, 32'h2000, 32'h3000, 16'd4, 8'd0, 0, 0, 32'h2);

    host_read(1'b1, rd);
`ifdef FAS_PERF_CNT_EN
    check("perf_cnt_nonzero", rd != 32'h0, 1'b1);
`else
    check("cfg_base_rb", rd, 32'h1000);
`endif

    // ReLU, read request acked before write request
    src_words.delete(); ref_words.delete();
    load_words(128'hFFFF_0005_FFFF_0005_FFFF_0005_FFFF_0005,
               128'h8000_7FFF_0001_FFFE_1234_ABCD_0000_8001,
               128'h0000_0005_0000_0005_0000_0005_0000_0005,
               128'h0000_7FFF_0001_0000_1234_0000_0000_0000);
    run_job(32'h1100, 32'h2100, 32'h3100, 16'd2, 8'd1, 1, 0, 32'h2);

    // unknown opcode: copy and flag err
    src_words.delete(); ref_words.delete();
    load_words(128'hFFFF_0005_FFFF_0005_FFFF_0005_FFFF_0005,
               128'h8000_7FFF_0001_FFFE_1234_ABCD_0000_8001,
               128'hFFFF_0005_FFFF_0005_FFFF_0005_FFFF_0005,
               128'h8000_7FFF_0001_FFFE_1234_ABCD_0000_8001);
    run_job(32'h1200, 32'h2200, 32'h3200, 16'd2, 8'd7, 0, 0, 32'h6);

    // zero-length job goes straight to the interrupt
    src_words.delete(); ref_words.delete();
    run_job(32'h1300, 32'h2300, 32'h3300, 16'd0, 8'd0, 0, 0, 32'h2);

    // back-pressure: 32 words against a 16-deep buffer, restart while busy
    src_words.delete(); ref_words.delete();
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(i);
      src_words.push_back({4{w}});
      ref_words.push_back({4{w}});
    end
    run_job(32'h1400, 32'h2400, 32'h3400, 16'd32, 8'd0, 1, 20, 32'h2);

    // reset mid-job abandons it
    host_write(REG_START, 32'h0);
    check("pre_rst_req", bus.init_read_req, 1'b1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check("rst_abandon_req", bus.init_read_req, 1'b0);
    check("rst_abandon_state", dbg_state, ST_IDLE);
    host_read(REG_STATUS, rd);
    check("rst_abandon_status", rd, 32'h0);
    host_read(1'b1, rd);
    check("rst_addr1_cleared", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
